// File: rtl/password_store.sv
// password_store: committed 4-digit BCD password with a serial set-password FSM.
module password_store #(
  parameter logic [15:0] DEFAULT_PASSWORD = 16'h0000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       setMode,
  input  logic       enable,
  input  logic [3:0] digit,
  input  logic [1:0] address,
  output logic [3:0] data,
  output logic       busy,
  output logic [1:0] captureIndex,
  output logic       setDoneLight,
  output logic       setErrorLight
);
  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;
  state_t state;
  logic [15:0] stored, shadow;
  logic set_mode_q;
  assign data = stored[{address, 2'b00} +: 4];
  assign busy = state != IDLE;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      stored <= DEFAULT_PASSWORD;
      shadow <= '0;
      set_mode_q <= 1'b0;
      captureIndex <= 2'd0;
      setDoneLight <= 1'b0;
      setErrorLight <= 1'b0;
    end else begin
      set_mode_q <= setMode;
      case (state)
        IDLE: if (setMode && !set_mode_q) begin
          state <= CAPTURE;
          captureIndex <= 2'd0;
          setDoneLight <= 1'b0;
          setErrorLight <= 1'b0;
        end
        CAPTURE: if (!setMode) begin
          state <= IDLE;
          captureIndex <= 2'd0;
        end else if (enable && digit <= 4'd9) begin
          shadow[{captureIndex, 2'b00} +: 4] <= digit;
          captureIndex <= captureIndex + 2'd1;
          if (captureIndex == 2'd3) state <= COMMIT;
        end else if (enable) begin
          state <= IDLE;
          setErrorLight <= 1'b1;
          captureIndex <= 2'd0;
        end
        COMMIT: begin
          stored <= shadow;
          setDoneLight <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_password_store.sv
// tb_password_store: directed stimulus with a queue-based scoreboard checked at the falling edge.
module tb_password_store;
  logic CLK = 1'b0, RST = 1'b0, setMode = 1'b0, enable = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [1:0] address = 2'd0;
  logic [3:0] data;
  logic busy, setDoneLight, setErrorLight;
  logic [1:0] captureIndex;
  int checks = 0, fails = 0;
  typedef struct {
    string n;
    logic [1:0] a;
    logic [3:0] d;
    logic b;
    logic [1:0] i;
    logic dn;
    logic er;
  } exp_t;
  exp_t q[$];
  localparam logic [15:0] DEF = 16'h9352;
  password_store #(.DEFAULT_PASSWORD(DEF)) dut (
    .CLK(CLK), .RST(RST), .setMode(setMode), .enable(enable), .digit(digit),
    .address(address), .data(data), .busy(busy), .captureIndex(captureIndex),
    .setDoneLight(setDoneLight), .setErrorLight(setErrorLight)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({data, busy, captureIndex, setDoneLight, setErrorLight} !== {e.d, e.b, e.i, e.dn, e.er}) begin
        fails++;
        $display("FAIL %s addr=%0d: got data=%0d busy=%b idx=%0d done=%b err=%b, want data=%0d busy=%b idx=%0d done=%b err=%b",
                 e.n, e.a, data, busy, captureIndex, setDoneLight, setErrorLight, e.d, e.b, e.i, e.dn, e.er);
      end
    end
  end
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic strobe(input logic [3:0] d);
    enable = 1'b1;
    digit = d;
    cyc();
    enable = 1'b0;
  endtask
  task automatic chk(input string n, input logic [1:0] a, input logic [3:0] d, input logic b,
                     input logic [1:0] i, input logic dn, input logic er);
    exp_t e;
    address = a;
    e = '{n: n, a: a, d: d, b: b, i: i, dn: dn, er: er};
    q.push_back(e);
    cyc();
  endtask
  task automatic sweep(input string n, input logic [15:0] pw, input logic b, input logic [1:0] i,
                       input logic dn, input logic er);
    for (int k = 0; k < 4; k++) chk(n, 2'(k), pw[4*k +: 4], b, i, dn, er);
  endtask
  task automatic rise();
    setMode = 1'b0;
    cyc();
    setMode = 1'b1;
    cyc();
  endtask
  initial begin
    repeat (2) cyc();
    RST = 1'b1;
    cyc();
    sweep("reset", DEF, 0, 0, 0, 0);
    rise();
    chk("capture_entry", 0, 4'd2, 1, 0, 0, 0);
    strobe(4); sweep("pre_commit1", DEF, 1, 1, 0, 0);
    strobe(7); sweep("pre_commit2", DEF, 1, 2, 0, 0);
    strobe(1); sweep("pre_commit3", DEF, 1, 3, 0, 0);
    strobe(8);
    chk("commit_cycle", 3, 4'd9, 1, 0, 0, 0);
    sweep("committed", 16'h8174, 0, 0, 1, 0);
    rise();
    chk("done_cleared", 0, 4'd4, 1, 0, 0, 0);
    strobe(6); strobe(6);
    chk("abort_pre", 1, 4'd7, 1, 2, 0, 0);
    setMode = 1'b0;
    cyc();
    sweep("aborted", 16'h8174, 0, 0, 0, 0);
    setMode = 1'b1;
    cyc();
    chk("restart", 0, 4'd4, 1, 0, 0, 0);
    strobe(5);
    chk("restart_idx", 0, 4'd4, 1, 1, 0, 0);
    rise();
    strobe(3);
    chk("inv_pre", 0, 4'd4, 1, 1, 0, 0);
    strobe(4'hB);
    sweep("invalid", 16'h8174, 0, 0, 0, 1);
    setMode = 1'b0;
    cyc();
    chk("err_sticky", 0, 4'd4, 0, 0, 0, 1);
    setMode = 1'b1;
    cyc();
    chk("err_cleared", 0, 4'd4, 1, 0, 0, 0);
    strobe(1); strobe(2); strobe(3);
    chk("idx3", 2, 4'd1, 1, 3, 0, 0);
    enable = 1'b1;
    digit = 4'd9;
    setMode = 1'b0;
    cyc();
    enable = 1'b0;
    sweep("abort_wins", 16'h8174, 0, 0, 0, 0);
    setMode = 1'b1;
    cyc();
    strobe(0); strobe(9); strobe(2); strobe(6);
    chk("commit2_cycle", 0, 4'd4, 1, 0, 0, 0);
    strobe(5); strobe(5);
    sweep("held_high", 16'h6290, 0, 0, 1, 0);
    rise();
    strobe(1); strobe(1); strobe(1);
    chk("pre_reset", 0, 4'd0, 1, 3, 0, 0);
    setMode = 1'b0;
    RST = 1'b0;
    chk("async_reset", 0, 4'd2, 0, 0, 0, 0);
    sweep("in_reset", DEF, 0, 0, 0, 0);
    RST = 1'b1;
    cyc();
    sweep("after_reset", DEF, 0, 0, 0, 0);
    for (int t = 0; t < 10 && q.size() > 0; t++) cyc();
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
